cacheline_adapter: RTL and testbench



---
 rtl/cacheline_adapter_pkg.sv | 15 +
 rtl/cacheline_adapter.sv | 143 ++++++++++++++
 tb/tb_cacheline_adapter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types for the L1 line port to burst-memory adapter.
package rv32i_types;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    DONE    = 3'd4
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line fills/writebacks into 64-bit memory bursts.
// Optional read-address tag check: define CACHELINE_ADAPTER_RADDR_CHECK_EN.
module cacheline_adapter
  import rv32i_types::*;
#(
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid,
  output logic                  bmem_err
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  adapter_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BURST_LEN-1:0][BEAT_WIDTH-1:0] line_q, line_d;
  logic [31:0] addr_d;
  logic [LINE_WIDTH-1:0] rdata_d;
  logic [BEAT_WIDTH-1:0] wdata_d;
  logic read_d, write_d, resp_d, beat_ok;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  logic err_d;
  logic unused_bits;
  assign unused_bits = ^dfp_addr[OFFSET_BITS-1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{dfp_addr[OFFSET_BITS-1:0], bmem_raddr};
  assign bmem_err = 1'b0;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
      dfp_resp   <= 1'b0;
      dfp_rdata  <= '0;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
      bmem_err   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      bmem_addr  <= addr_d;
      bmem_read  <= read_d;
      bmem_write <= write_d;
      bmem_wdata <= wdata_d;
      dfp_resp   <= resp_d;
      dfp_rdata  <= rdata_d;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
      bmem_err   <= err_d;
`endif
    end
  end

  // Next state, datapath updates and next output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = bmem_addr;
    rdata_d = dfp_rdata;
    beat_ok = 1'b0;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    err_d   = bmem_err;
`endif

    case (state_q)
      IDLE: begin
        if (dfp_write || dfp_read) begin
          addr_d  = {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          line_d  = dfp_wdata;
          cnt_d   = '0;
          state_d = dfp_write ? WR_DATA : RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        beat_ok = bmem_rvalid;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
        // A beat tagged with a foreign address belongs to nobody; drop it
        if (bmem_rvalid && (bmem_raddr != bmem_addr)) begin
          beat_ok = 1'b0;
          err_d   = 1'b1;
        end
`endif
        if (beat_ok) begin
          line_d[cnt_q] = bmem_rdata;
          cnt_d         = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            rdata_d = line_d;
          end
        end
      end
      WR_DATA: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    read_d  = (state_d == RD_REQ);
    write_d = (state_d == WR_DATA);
    resp_d  = (state_d == DONE);
    wdata_d = write_d ? line_d[cnt_d] : bmem_wdata;
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter with an in-bench memory responder and line model.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         bmem_err;

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;
  int lat;

  cacheline_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .bmem_err(bmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_resp"},  256'(dfp_resp),   256'(0));
    chk({tag, "_read"},  256'(bmem_read),  256'(0));
    chk({tag, "_write"}, 256'(bmem_write), 256'(0));
    chk({tag, "_addr"},  256'(bmem_addr),  256'(0));
    chk({tag, "_wdata"}, 256'(bmem_wdata), 256'(0));
    chk({tag, "_err"},   256'(bmem_err),   256'(0));
    chk({tag, "_rdata"}, dfp_rdata,        256'(0));
  endtask

  // Line fill: memory answers with the beats of 'line' in order, gaps from a pattern or at random
  task automatic do_fill(input string name, input logic [31:0] addr, input logic [255:0] line,
                         input bit use_pat, input logic [31:0] vpat, input int unsigned gap_pct,
                         input bit inject_bad, output int latency);
    int sent = 0;
    int cyc = 0;
    int dcyc = 0;
    int resp_cnt = 0;
    bit req_done = 1'b0;
    bit bad_done = 1'b0;
    bit last;
    bit vsel;
    logic [63:0] b;
    @(negedge clk);
    dfp_addr = addr; dfp_wdata = {8{$urandom}}; dfp_read = 1'b1;
    @(negedge clk);
    dfp_read = 1'b0; dfp_addr = $urandom; dfp_wdata = '0;
    chk({name, "_addr"}, 256'(bmem_addr), 256'(align(addr)));
    while (resp_cnt == 0 && cyc < 300) begin
      last = 1'b0;
      bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      bmem_raddr = $urandom; bmem_rdata = {$urandom, $urandom};
      chk({name, "_read"}, 256'(bmem_read), 256'(!req_done));
      if (!req_done) begin
        bmem_ready  = use_pat ? 1'b1 : ($urandom_range(99) >= gap_pct);
        bmem_rvalid = 1'($urandom_range(1));
        if (bmem_ready) req_done = 1'b1;
      end else begin
        vsel = use_pat ? vpat[dcyc % 32] : ($urandom_range(99) >= gap_pct);
        if (sent < 4 && vsel) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = align(addr);
          b = line[64*sent +: 64];
          if (inject_bad && !bad_done && sent == 1) begin
            bad_done   = 1'b1;
            bmem_raddr = 32'hDEAD_0000;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
            bmem_rdata = ~b;
            exp_err    = 1'b1;
`else
            bmem_rdata = b;
            sent++;
            last = (sent == 4);
`endif
          end else begin
            bmem_rdata = b;
            sent++;
            last = (sent == 4);
          end
        end
        dcyc++;
      end
      @(negedge clk);
      cyc++;
      chk({name, "_resp"}, 256'(dfp_resp), 256'(last));
      chk({name, "_err"},  256'(bmem_err), 256'(exp_err));
      if (dfp_resp) begin
        resp_cnt++;
        chk({name, "_rdata"}, dfp_rdata, line);
      end
    end
    bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    chk({name, "_done"}, 256'(resp_cnt), 256'(1));
    latency = cyc;
    @(negedge clk);
    chk({name, "_pulse"}, 256'(dfp_resp), 256'(0));
    chk({name, "_hold"},  dfp_rdata, line);
  endtask

  // Writeback: every beat must match the line slice in order and stay put until accepted
  task automatic do_wb(input string name, input logic [31:0] addr, input logic [255:0] line,
                       input bit both, input bit use_pat, input logic [31:0] rpat,
                       input int unsigned gap_pct, output int latency);
    int acc = 0;
    int cyc = 0;
    int resp_cnt = 0;
    bit last;
    logic [255:0] prior;
    prior = dfp_rdata;
    @(negedge clk);
    dfp_addr = addr; dfp_wdata = line; dfp_write = 1'b1; dfp_read = both;
    @(negedge clk);
    dfp_write = 1'b0; dfp_read = 1'b0; dfp_wdata = {8{$urandom}}; dfp_addr = $urandom;
    while (resp_cnt == 0 && cyc < 300) begin
      last = 1'b0;
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'($urandom_range(1));
      bmem_raddr  = $urandom;
      bmem_rdata  = {$urandom, $urandom};
      chk({name, "_noread"}, 256'(bmem_read),  256'(0));
      chk({name, "_write"},  256'(bmem_write), 256'(acc < 4));
      if (acc < 4) begin
        chk({name, "_wdata"}, 256'(bmem_wdata), 256'(line[64*acc +: 64]));
        chk({name, "_addr"},  256'(bmem_addr),  256'(align(addr)));
        bmem_ready = use_pat ? rpat[cyc % 32] : ($urandom_range(99) >= gap_pct);
        if (bmem_ready) begin
          acc++;
          last = (acc == 4);
        end
      end
      @(negedge clk);
      cyc++;
      chk({name, "_resp"}, 256'(dfp_resp), 256'(last));
      chk({name, "_err"},  256'(bmem_err), 256'(exp_err));
      if (dfp_resp) resp_cnt++;
    end
    bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    chk({name, "_done"}, 256'(resp_cnt), 256'(1));
    latency = cyc;
    @(negedge clk);
    chk({name, "_pulse"},      256'(dfp_resp), 256'(0));
    chk({name, "_rdata_keep"}, dfp_rdata, prior);
  endtask

  initial begin
    logic [255:0] l;
    rst_n = 1'b0;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Directed fill at minimum latency
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_fill("fill", 32'h1234_5678, l, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, lat);
    chk("fill_bmem_addr_const", 256'(align(32'h1234_5678)), 256'(32'h1234_5660));
    chk("fill_latency", 256'(lat), 256'(5));

    // Directed writeback with a two-cycle stall after beat 0
    do_wb("wb", 32'h0000_0040, {64'd3, 64'd2, 64'd1, 64'd0}, 1'b0, 1'b1, 32'hFFFF_FFF9, 0, lat);
    chk("wb_latency", 256'(lat), 256'(6));
    do_wb("wb_min", $urandom, {8{$urandom}}, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, lat);
    chk("wb_min_latency", 256'(lat), 256'(4));

    // Three idle cycles between beats 1 and 2
    do_fill("fill_gap", $urandom, {8{$urandom}}, 1'b1, 32'h0000_0063, 0, 1'b0, lat);
    chk("fill_gap_latency", 256'(lat), 256'(8));

    // Read and write requested together: write wins
    do_wb("both", $urandom, {8{$urandom}}, 1'b1, 1'b0, '0, 30, lat);

    // Foreign read-address tag on one beat
    do_fill("raddr", $urandom, {8{$urandom}}, 1'b0, '0, 20, 1'b1, lat);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1) == 1)
        do_fill("rnd_fill", $urandom, {8{$urandom}}, 1'b0, '0, $urandom_range(60), 1'b0, lat);
      else
        do_wb("rnd_wb", $urandom, {8{$urandom}}, 1'($urandom_range(1)), 1'b0, '0,
              $urandom_range(60), lat);
    end

    // Reset in the middle of a fill, two beats in
    @(negedge clk);
    dfp_addr = 32'h0000_0200; dfp_read = 1'b1;
    @(negedge clk);
    dfp_read = 1'b0; bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0; bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0200;
    bmem_rdata = {16{4'hA}};
    @(negedge clk);
    bmem_rdata = {16{4'hB}};
    @(negedge clk);
    bmem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("after_reset");
    do_fill("post_reset", 32'h0000_0100, {8{$urandom}}, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, lat);
    chk("post_reset_latency", 256'(lat), 256'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
